// File: rtl/pulse_pacer.sv
// pulse_pacer
// Source-domain conditioner that sits in front of a toggle pulse synchronizer.
// Bursty single-cycle events are counted when they cannot be forwarded at
// once. They are re-emitted as single-cycle pulses whose rising edges are at
// least GAP clk_i cycles apart, so the downstream toggle is never lost. Events
// that arrive while the pending counter is full are dropped, and a sticky flag
// records the drop.
//
// Ports:
//   clk_i      : the single clock (source domain)
//   rstn_i     : asynchronous active-low reset
//   puls_i     : event pulse; every high cycle is one event
//   ovf_clr_i  : clears the sticky overflow flag on the next edge
//   puls_o     : paced single-cycle pulse, registered
//   pend_o     : number of events still waiting to be emitted, registered
//   busy_o     : a gap is running or events are pending
//   ovf_o      : sticky, at least one event was dropped
module pulse_pacer #(
  parameter int GAP   = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             puls_i,
  input  logic             ovf_clr_i,
  output logic             puls_o,
  output logic [CNT_W-1:0] pend_o,
  output logic             busy_o,
  output logic             ovf_o
);

  // The gap counter only has to hold GAP-1; GAP >= 2 keeps GW >= 1.
  localparam int GW = $clog2(GAP);
  localparam logic [GW-1:0]    GapLoad = GW'(GAP - 1);
  localparam logic [GW-1:0]    GapOne  = GW'(1);
  localparam logic [CNT_W-1:0] PendMax = '1;
  localparam logic [CNT_W-1:0] PendOne = CNT_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             puls_q;
  logic             fire;
  logic             drop;

  // A pulse leaves whenever no gap is running and there is something to send.
  // A fresh input event can go straight out without first being counted.
  assign fire = (state_q == ST_IDLE) && ((pend_q != '0) || puls_i);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    drop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          state_d = ST_GAP;
          gap_d   = GapLoad;
        end
      end
      ST_GAP: begin
        gap_d = gap_q - GapOne;
        // Leaving on the count of one makes the next fire exactly GAP
        // cycles after the previous one.
        if (gap_q == GapOne) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = '0;
      end
    endcase

    // Arrival and departure in the same cycle cancel out. A departure without
    // an arrival always has a pending event behind it, so no underflow.
    if (puls_i && !fire) begin
      if (pend_q == PendMax) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + PendOne;
      end
    end else if (!puls_i && fire) begin
      pend_d = pend_q - PendOne;
    end

    // A drop in the same cycle as a clear must still leave the flag set.
    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      puls_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      puls_q  <= fire;
    end
  end

  assign puls_o = puls_q;
  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;
  assign busy_o = (state_q == ST_GAP) || (pend_q != '0);

endmodule

// File: tb/tb_pulse_pacer.sv
// tb_pulse_pacer
// Directed scenarios followed by a random burst phase for pulse_pacer
// (GAP=4, CNT_W=2, so the pending capacity is 3). The reference model works
// in terms of time since the last emitted pulse and a plain integer backlog.
module tb_pulse_pacer;

  localparam int GAP   = 4;
  localparam int CNT_W = 2;
  localparam int PMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rstn_i;
  logic             puls_i;
  logic             ovf_clr_i;
  logic             puls_o;
  logic [CNT_W-1:0] pend_o;
  logic             busy_o;
  logic             ovf_o;

  int checks = 0;
  int errors = 0;

  // Reference model: current cycle index, cycle of the last emitted pulse,
  // backlog, expected registered outputs and event bookkeeping.
  int modelCycle;
  int lastFire;
  int pend;
  bit expPuls;
  bit expOvf;
  int nIn;
  int nOutObs;
  int nDrop;

  pulse_pacer #(
    .GAP  (GAP),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i    (clk),
    .rstn_i   (rstn_i),
    .puls_i   (puls_i),
    .ovf_clr_i(ovf_clr_i),
    .puls_o   (puls_o),
    .pend_o   (pend_o),
    .busy_o   (busy_o),
    .ovf_o    (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    modelCycle = 0;
    lastFire   = -100;
    pend       = 0;
    expPuls    = 1'b0;
    expOvf     = 1'b0;
    nIn        = 0;
    nOutObs    = 0;
    nDrop      = 0;
  endtask

  // Compares all outputs with the model for the current cycle.
  task automatic checkOutput(input string tag);
    bit expBusy;
    expBusy = ((modelCycle - lastFire) < GAP) || (pend > 0);
    check({tag, ".puls"}, int'(puls_o), int'(expPuls));
    check({tag, ".pend"}, int'(pend_o), pend);
    check({tag, ".busy"}, int'(busy_o), int'(expBusy));
    check({tag, ".ovf"},  int'(ovf_o),  int'(expOvf));
    if (puls_o === 1'b1) nOutObs++;
  endtask

  // Drives one cycle of inputs, advances the model over the clock edge and
  // checks the outputs shortly after the edge.
  task automatic applyStimulus(input bit inP, input bit clr, input string tag);
    bit fire;
    int nextPend;
    puls_i    = inP;
    ovf_clr_i = clr;
    @(posedge clk);
    fire     = ((modelCycle - lastFire) >= GAP) && ((pend > 0) || inP);
    nextPend = pend + int'(inP) - int'(fire);
    if (inP) nIn++;
    if (nextPend > PMAX) begin
      nextPend = PMAX;
      nDrop++;
      expOvf = 1'b1;
    end else if (clr) begin
      expOvf = 1'b0;
    end
    expPuls = fire;
    if (fire) lastFire = modelCycle;
    pend = nextPend;
    modelCycle++;
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, tag);
  endtask

  // Asserts reset between clock edges, checks that it acts immediately, holds
  // it for two edges and releases it away from an edge.
  task automatic doReset(input string tag);
    puls_i    = 1'b0;
    ovf_clr_i = 1'b0;
    #2;
    rstn_i = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, "_hold"});
    rstn_i = 1'b1;
  endtask

  initial begin
    puls_i    = 1'b0;
    ovf_clr_i = 1'b0;
    rstn_i    = 1'b0;
    modelReset();
    #1;
    checkOutput("reset");
    repeat (2) @(posedge clk);
    #1;
    rstn_i = 1'b1;

    // Single isolated pulse.
    $display("[TB] single pulse");
    applyStimulus(1'b1, 1'b0, "s1");
    check("s1.first_puls", int'(puls_o), 1);
    idle(6, "s1");

    // Five back-to-back events, backlog peaks at 3 without overflow.
    $display("[TB] burst of five");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, "s2");
    idle(20, "s2");
    check("s2.no_ovf", int'(ovf_o), 0);

    // Six events: the last one overflows the 3-deep backlog.
    $display("[TB] burst of six");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, "s3");
    idle(20, "s3");
    check("s3.ovf_set", int'(ovf_o), 1);
    check("s3.drops", nDrop, 1);

    // Clear alone, then a drop in the same cycle as a clear.
    $display("[TB] overflow clear");
    applyStimulus(1'b0, 1'b1, "s4a");
    check("s4.ovf_cleared", int'(ovf_o), 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, "s4b");
    applyStimulus(1'b1, 1'b1, "s4c");
    check("s4.set_wins", int'(ovf_o), 1);
    idle(20, "s4d");
    applyStimulus(1'b0, 1'b1, "s4e");

    // Second event arrives exactly as the gap ends and bypasses the counter.
    $display("[TB] bypass at gap end");
    applyStimulus(1'b1, 1'b0, "s5");
    idle(3, "s5");
    applyStimulus(1'b1, 1'b0, "s5");
    check("s5.bypass_puls", int'(puls_o), 1);
    check("s5.bypass_pend", int'(pend_o), 0);
    idle(8, "s5");

    // Reset in the middle of a gap with a backlog.
    $display("[TB] reset mid-gap");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, "s6");
    applyStimulus(1'b0, 1'b0, "s6");
    doReset("s6_rst");
    applyStimulus(1'b1, 1'b0, "s6_after");
    check("s6.fresh_puls", int'(puls_o), 1);
    idle(6, "s6_after");

    // Random bursts with occasional clears, then drain and check conservation.
    $display("[TB] random phase");
    doReset("rnd_rst");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) < 45), ($urandom_range(0, 31) == 0), "rnd");
    end
    idle(20, "rnd_drain");
    check("rnd.conservation", nOutObs + nDrop + int'(pend_o), nIn);
    check("rnd.drained", int'(busy_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
